hazard1_shift_arb: RTL
======================

# hazard1_shift_arb

Two-port arbiter and sequencer that shares a single `hazard1_shift_barrel` instance between two requesters, for example the ALU shift path and the load/store byte-lane alignment path. It accepts shift requests over valid/ready handshakes and grants at most one request per cycle. The granted operands go through the barrel shifter combinationally, and the result is captured in a one-entry response register tagged with the requester ID. Sustained throughput is one shift per cycle.

## Interface
Parameters:
- none; data width is fixed at 32 and shift amount at 5 bits, to match the shifter.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  2  per-port request valid; bit i belongs to port i.
- `req_ready`  out  2  per-port accept; a request transfers when `req_valid[i] && req_ready[i]`.
- `req_din`  in  64  operands; port i uses bits `[32*i+31:32*i]`.
- `req_shamt`  in  10  shift amounts; port i uses bits `[5*i+4:5*i]`.
- `req_right_nleft`  in  2  1 = shift right, 0 = shift left.
- `req_arith`  in  2  1 = sign-fill; honoured on right shifts only.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_ready`  in  1  consumer accepts the response this cycle.
- `rsp_id`  out  1  index of the port that issued the held result.
- `rsp_dout`  out  32  held shift result.

## Operation
- Stage free: `free = !rsp_valid || rsp_ready`.
- Grant is combinational from `req_valid`, the priority state and `free`. At most one `req_ready` bit is high, and only when `free`.
- With only one port valid, that port is granted.
- With both ports valid, the arbitration policy (see Configuration) picks the winner.
- The granted port's din, shamt and right_nleft drive the shifter. The shifter's arith input is `req_arith[g] && req_right_nleft[g]`, so a left shift always zero-fills. The shifter's rotate input is tied to 0.
- On accept:
  - `rsp_dout` is loaded with the shifter output.
  - `rsp_id` is loaded with g.
  - `rsp_valid` is set to 1.
- On `rsp_valid && rsp_ready` with no new accept, `rsp_valid` clears to 0.
- Requester rules:
  - A requester must hold valid and operands stable until accepted.
  - The grant cannot move away from a valid, unaccepted port, because the priority state changes only on accept.
- The consumer may assert `rsp_ready` at any time. `rsp_dout` and `rsp_id` are stable while `rsp_valid && !rsp_ready`.
- Shift arithmetic:
  - shamt 0 passes din unchanged.
  - shamt 31 right arith on a negative operand gives 0xFFFFFFFF.
  - No shift amount of 32 or more exists, since shamt is 5 bits.

## Timing
- Latency: a request accepted in cycle N has its result on `rsp_dout`/`rsp_valid` in cycle N+1.
- Throughput: one accept per cycle while `rsp_ready` is held high.
- Backpressure: with `rsp_valid=1` and `rsp_ready=0`, both `req_ready` bits are 0. The held result is kept indefinitely.
- Simultaneous response drain and new accept in the same cycle:
  - the register reloads;
  - `rsp_valid` stays 1;
  - no bubble is inserted.
- Reset values:
  - `rsp_valid=0`, `rsp_id=0`, `rsp_dout=0x00000000`;
  - priority state set so port 0 wins the first contention.
- Reset asserted mid-operation discards the held result and resets the priority state. `req_ready` is 0 during the reset cycle.

## Configuration
- `HAZARD1_SHIFT_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit `last_grant` register updates on every accept.
  - On contention, the port not most recently granted wins.
  - The first contention after reset goes to port 0.
- `HAZARD1_SHIFT_ARB_RR_EN` undefined: fixed priority.
  - Port 0 always wins contention.
  - No priority register exists.
  - Port 1 can be starved indefinitely.

## Test plan
- Single shift, port 0: din 0x80000000, shamt 4, right, arith=1 with `rsp_ready=1` -> next cycle `rsp_valid=1`, `rsp_id=0`, `rsp_dout=0xF8000000`. Same request with arith=0 -> 0x08000000.
- Left arith ignored: port 1, din 0x00000001, shamt 4, left, arith=1 -> `rsp_dout=0x00000010`, `rsp_id=1`. A 31-bit left shift of 0x00000001 -> 0x80000000.
- Contention: both ports valid for 4 consecutive accepts, `rsp_ready=1`, port 0 din 0x11111111, port 1 din 0x22222222, shamt 0.
  - With RR: `rsp_id` sequence 0,1,0,1.
  - Without RR: 0,0,0,0, and `req_ready[1]` stays 0 throughout.
- Backpressure: hold `rsp_ready=0` for 3 cycles after an accept -> `req_ready=2'b00`, `rsp_dout`/`rsp_id` stable. Raising `rsp_ready` with a pending request -> drain and reload in the same cycle, `rsp_valid` stays 1.
- Reset mid-operation: assert `rst` while `rsp_valid=1` -> next cycle `rsp_valid=0`, `rsp_dout=0`. The first post-reset contention grants port 0.
- Randomised stream: random valids, operands and `rsp_ready` over 10k cycles.
  - Every accepted request produces exactly one response, in order.
  - Each response equals the reference shift of its operands.
  - No response is dropped or duplicated.

Source files
------------

// File: rtl/hazard1_shift_arb_if.sv
// Request/response bundle for hazard1_shift_arb.
// Port i of each request field occupies slice i (32-bit din, 5-bit shamt, 1-bit flags).
interface hazard1_shift_arb_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_din;
  logic [9:0]  req_shamt;
  logic [1:0]  req_right_nleft;
  logic [1:0]  req_arith;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_dout;

  // Arbiter side
  modport slave (
    input  req_valid, req_din, req_shamt, req_right_nleft, req_arith, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_dout
  );

  // Requesters plus response consumer
  modport master (
    output req_valid, req_din, req_shamt, req_right_nleft, req_arith, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_dout
  );
endinterface

// File: rtl/hazard1_shift_arb.sv
// Two-port arbiter sharing one 32-bit barrel shifter, with a one-entry tagged response register.
// Optional feature: define HAZARD1_SHIFT_ARB_RR_EN for round-robin arbitration; otherwise
// port 0 has fixed priority on contention.
module hazard1_shift_arb (
  input  logic               clk,
  input  logic               rst,
  hazard1_shift_arb_if.slave bus
);

  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [31:0] r_rsp_dout;
`ifdef HAZARD1_SHIFT_ARB_RR_EN
  logic        r_last_grant;
`endif

  logic        w_free;
  logic        w_accept;
  logic        w_gnt;
  logic [1:0]  w_ready;
  logic [31:0] w_sh_din;
  logic [4:0]  w_sh_shamt;
  logic        w_sh_right;
  logic        w_sh_arith;
  logic        w_fill;
  logic [31:0] w_pre;
  logic [31:0] w_s1, w_s2, w_s3, w_s4, w_s5;
  logic [31:0] w_sh_dout;

  // The stage can take a new result if it is empty or being drained this cycle.
  assign w_free = !r_rsp_valid || bus.rsp_ready;

  // Winner select: a lone requester wins outright, contention goes to the policy.
  always_comb begin
    w_gnt = 1'b0;
    case (bus.req_valid)
      2'b10:   w_gnt = 1'b1;
`ifdef HAZARD1_SHIFT_ARB_RR_EN
      2'b11:   w_gnt = ~r_last_grant;
`else
      2'b11:   w_gnt = 1'b0;
`endif
      default: w_gnt = 1'b0;
    endcase
  end

  // Accept needs a valid requester, a free stage and no reset in progress.
  assign w_accept = (|bus.req_valid) && w_free && !rst;
  assign w_ready  = w_accept ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;

  // Granted operands feed the shared shifter; left shifts always zero-fill.
  assign w_sh_din   = w_gnt ? bus.req_din[63:32] : bus.req_din[31:0];
  assign w_sh_shamt = w_gnt ? bus.req_shamt[9:5] : bus.req_shamt[4:0];
  assign w_sh_right = bus.req_right_nleft[w_gnt];
  assign w_sh_arith = bus.req_arith[w_gnt] && bus.req_right_nleft[w_gnt];
  assign w_fill     = w_sh_arith && w_sh_din[31];

  // Left shifts reuse the right-shift stages on bit-reversed data; rotate is not used.
  always_comb begin
    w_pre = '0;
    for (int i = 0; i < 32; i++) begin
      w_pre[i] = w_sh_right ? w_sh_din[i] : w_sh_din[31-i];
    end
  end

  assign w_s1 = w_sh_shamt[0] ? {w_fill, w_pre[31:1]}        : w_pre;
  assign w_s2 = w_sh_shamt[1] ? {{2{w_fill}}, w_s1[31:2]}    : w_s1;
  assign w_s3 = w_sh_shamt[2] ? {{4{w_fill}}, w_s2[31:4]}    : w_s2;
  assign w_s4 = w_sh_shamt[3] ? {{8{w_fill}}, w_s3[31:8]}    : w_s3;
  assign w_s5 = w_sh_shamt[4] ? {{16{w_fill}}, w_s4[31:16]}  : w_s4;

  // Undo the bit reversal for left shifts.
  always_comb begin
    w_sh_dout = '0;
    for (int i = 0; i < 32; i++) begin
      w_sh_dout[i] = w_sh_right ? w_s5[i] : w_s5[31-i];
    end
  end

  // Response register: reload on accept (even while draining), otherwise clear when drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_dout  <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_gnt;
      r_rsp_dout  <= w_sh_dout;
    end else if (bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef HAZARD1_SHIFT_ARB_RR_EN
  // Priority state moves only on accept, so a waiting requester keeps its claim.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_gnt;
    end
  end
`endif

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_dout  = r_rsp_dout;

endmodule
